// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory-access stage: bus widths, aluop codes for the
// memory instructions, and the stage FSM state encoding.
package mem_stage_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned AluOpBus   = 8;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  typedef logic [AluOpBus-1:0] aluop_t;

  localparam aluop_t EXE_NOP_OP  = 8'b0000_0000;
  localparam aluop_t EXE_ADDU_OP = 8'b0010_0001;
  localparam aluop_t EXE_LB_OP   = 8'b1110_0000;
  localparam aluop_t EXE_LBU_OP  = 8'b1110_0100;
  localparam aluop_t EXE_LH_OP   = 8'b1110_0001;
  localparam aluop_t EXE_LHU_OP  = 8'b1110_0101;
  localparam aluop_t EXE_LW_OP   = 8'b1110_0011;
  localparam aluop_t EXE_LL_OP   = 8'b1111_0000;
  localparam aluop_t EXE_SB_OP   = 8'b1110_1000;
  localparam aluop_t EXE_SH_OP   = 8'b1110_1001;
  localparam aluop_t EXE_SW_OP   = 8'b1110_1011;
  localparam aluop_t EXE_SC_OP   = 8'b1111_1000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StDone  = 2'd2,
    StDrain = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_align.sv
// Big-endian lane logic for the memory stage (purely combinational).
//   aluop_i    : operation code
//   addr_lo_i  : effective address bits [1:0]
//   reg2_i     : store source data
//   rdata_i    : bus read data
//   is_load_o / is_store_o : operation class
//   misalign_o : address not aligned to the access size
//   sel_o      : byte lane enables (bit3 = bits[31:24])
//   wdata_o    : store data replicated across lanes
//   ldata_o    : extracted and sign/zero-extended load data
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [AluOpBus-1:0] aluop_i,
  input  logic [1:0]          addr_lo_i,
  input  logic [RegBus-1:0]   reg2_i,
  input  logic [RegBus-1:0]   rdata_i,
  output logic                is_load_o,
  output logic                is_store_o,
  output logic                misalign_o,
  output logic [3:0]          sel_o,
  output logic [RegBus-1:0]   wdata_o,
  output logic [RegBus-1:0]   ldata_o
);

  logic [7:0]  byte_data;
  logic [15:0] half_data;
  logic [3:0]  byte_lane;
  logic [3:0]  half_lane;

  always_comb begin
    unique case (addr_lo_i)
      2'b00:   byte_data = rdata_i[31:24];
      2'b01:   byte_data = rdata_i[23:16];
      2'b10:   byte_data = rdata_i[15:8];
      default: byte_data = rdata_i[7:0];
    endcase
    half_data = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    byte_lane = 4'b1000 >> addr_lo_i;
    half_lane = addr_lo_i[1] ? 4'b0011 : 4'b1100;
  end

  always_comb begin
    is_load_o  = 1'b0;
    is_store_o = 1'b0;
    misalign_o = 1'b0;
    sel_o      = 4'b0000;
    wdata_o    = ZeroWord;
    ldata_o    = ZeroWord;
    case (aluop_i)
      EXE_LB_OP: begin
        is_load_o = 1'b1;
        sel_o     = byte_lane;
        ldata_o   = {{24{byte_data[7]}}, byte_data};
      end
      EXE_LBU_OP: begin
        is_load_o = 1'b1;
        sel_o     = byte_lane;
        ldata_o   = {24'b0, byte_data};
      end
      EXE_LH_OP: begin
        is_load_o  = 1'b1;
        misalign_o = addr_lo_i[0];
        sel_o      = half_lane;
        ldata_o    = {{16{half_data[15]}}, half_data};
      end
      EXE_LHU_OP: begin
        is_load_o  = 1'b1;
        misalign_o = addr_lo_i[0];
        sel_o      = half_lane;
        ldata_o    = {16'b0, half_data};
      end
      EXE_LW_OP, EXE_LL_OP: begin
        is_load_o  = 1'b1;
        misalign_o = |addr_lo_i;
        sel_o      = 4'b1111;
        ldata_o    = rdata_i;
      end
      EXE_SB_OP: begin
        is_store_o = 1'b1;
        sel_o      = byte_lane;
        wdata_o    = {4{reg2_i[7:0]}};
      end
      EXE_SH_OP: begin
        is_store_o = 1'b1;
        misalign_o = addr_lo_i[0];
        sel_o      = half_lane;
        wdata_o    = {2{reg2_i[15:0]}};
      end
      EXE_SW_OP, EXE_SC_OP: begin
        is_store_o = 1'b1;
        misalign_o = |addr_lo_i;
        sel_o      = 4'b1111;
        wdata_o    = reg2_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage between EX/MEM and MEM/WB.
//   clk, rst            : clock, asynchronous active-low reset
//   wd_i/wreg_i/wdata_i : writeback info from EX/MEM; *_o forwarded to MEM/WB
//   hi_i/lo_i/whilo_i   : HI/LO writeback, forwarded (whilo_o masked while stalling)
//   aluop_i, mem_addr_i, reg2_i : memory operation, effective address, store data
//   flush_i             : pipeline flush
//   dbus_*              : req/ack data bus, word addressed with byte lane selects
//   stallreq_o          : hold the pipeline while a bus access is outstanding
//   adel_o / ades_o     : load / store address error
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DATA_W     = RegBus,
  parameter int unsigned REG_ADDR_W = RegAddrBus,
  parameter int unsigned ALUOP_W    = AluOpBus
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W-1:0]     hi_i,
  input  logic [DATA_W-1:0]     lo_i,
  input  logic                  whilo_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [DATA_W-1:0]     mem_addr_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic                  flush_i,
  input  logic                  dbus_ack_i,
  input  logic [DATA_W-1:0]     dbus_rdata_i,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [DATA_W-1:0]     dbus_addr_o,
  output logic [3:0]            dbus_sel_o,
  output logic [DATA_W-1:0]     dbus_wdata_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  whilo_o,
  output logic                  stallreq_o,
  output logic                  adel_o,
  output logic                  ades_o
);

  mem_state_e        state_q, state_d;
  logic              llbit_q, llbit_d;
  logic [DATA_W-1:0] load_q, load_d;

  // Request is captured at launch so a flushed EX/MEM cannot disturb an access in flight.
  logic              req_we_q, req_we_d;
  logic [DATA_W-1:0] req_addr_q, req_addr_d;
  logic [3:0]        req_sel_q, req_sel_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

  logic              is_load, is_store, misalign;
  logic [3:0]        sel;
  logic [DATA_W-1:0] st_wdata, ld_data, word_addr;
  logic              is_ll, is_sc;
  logic              stall, kill;

  assign is_ll     = (aluop_i == EXE_LL_OP);
  assign is_sc     = (aluop_i == EXE_SC_OP);
  assign word_addr = {mem_addr_i[DATA_W-1:2], 2'b00};

  mem_align u_mem_align (
    .aluop_i    (aluop_i),
    .addr_lo_i  (mem_addr_i[1:0]),
    .reg2_i     (reg2_i),
    .rdata_i    (dbus_rdata_i),
    .is_load_o  (is_load),
    .is_store_o (is_store),
    .misalign_o (misalign),
    .sel_o      (sel),
    .wdata_o    (st_wdata),
    .ldata_o    (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      llbit_q     <= 1'b0;
      load_q      <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_sel_q   <= 4'b0000;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      llbit_q     <= llbit_d;
      load_q      <= load_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_sel_q   <= req_sel_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    llbit_d      = llbit_q;
    load_d       = load_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_sel_d    = req_sel_q;
    req_wdata_d  = req_wdata_q;
    wd_o         = wd_i;
    wreg_o       = wreg_i;
    wdata_o      = wdata_i;
    hi_o         = hi_i;
    lo_o         = lo_i;
    whilo_o      = whilo_i;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = '0;
    dbus_sel_o   = 4'b0000;
    dbus_wdata_o = '0;
    adel_o       = 1'b0;
    ades_o       = 1'b0;
    stall        = 1'b0;
    kill         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (flush_i) begin
          kill = 1'b1;
        end else if (misalign) begin
          adel_o = is_load;
          ades_o = is_store;
          wreg_o = 1'b0;
        end else if (is_sc && !llbit_q) begin
          // Failed store-conditional: report 0 without touching the bus.
          wreg_o  = 1'b1;
          wdata_o = '0;
        end else if (is_load || is_store) begin
          dbus_req_o   = 1'b1;
          dbus_we_o    = is_store;
          dbus_addr_o  = word_addr;
          dbus_sel_o   = sel;
          dbus_wdata_o = st_wdata;
          stall        = 1'b1;
          wreg_o       = 1'b0;
          req_we_d     = is_store;
          req_addr_d   = word_addr;
          req_sel_d    = sel;
          req_wdata_d  = st_wdata;
          state_d      = StBusy;
        end
      end
      StBusy, StDrain: begin
        dbus_req_o   = 1'b1;
        dbus_we_o    = req_we_q;
        dbus_addr_o  = req_addr_q;
        dbus_sel_o   = req_sel_q;
        dbus_wdata_o = req_wdata_q;
        stall        = 1'b1;
        wreg_o       = 1'b0;
        if (state_q == StBusy) begin
          if (dbus_ack_i) begin
            if (is_load) load_d = ld_data;
            if (is_ll) llbit_d = 1'b1;
            if (is_sc) llbit_d = 1'b0;
            state_d = flush_i ? StIdle : StDone;
          end else if (flush_i) begin
            state_d = StDrain;
          end
        end else if (dbus_ack_i) begin
          state_d = StIdle;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (flush_i) begin
          kill = 1'b1;
        end else if (is_load) begin
          wdata_o = load_q;
        end else if (is_sc) begin
          wdata_o = DATA_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush beats a simultaneous LL completion.
    if (flush_i) llbit_d = 1'b0;
    if (stall) whilo_o = 1'b0;

    if (kill || !rst) begin
      wd_o         = '0;
      wreg_o       = 1'b0;
      wdata_o      = '0;
      hi_o         = '0;
      lo_o         = '0;
      whilo_o      = 1'b0;
      dbus_req_o   = 1'b0;
      dbus_we_o    = 1'b0;
      dbus_addr_o  = '0;
      dbus_sel_o   = 4'b0000;
      dbus_wdata_o = '0;
      adel_o       = 1'b0;
      ades_o       = 1'b0;
      stall        = 1'b0;
    end
  end

  assign stallreq_o = stall;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized stream, all checked
// against a transaction-level model of lane selection, extension and the LL link bit.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  wd_i = '0, wd_o;
  logic        wreg_i = 1'b0, wreg_o;
  logic [31:0] wdata_i = '0, wdata_o;
  logic [31:0] hi_i = '0, lo_i = '0, hi_o, lo_o;
  logic        whilo_i = 1'b0, whilo_o;
  logic [7:0]  aluop_i = '0;
  logic [31:0] mem_addr_i = '0, reg2_i = '0;
  logic        flush_i = 1'b0;
  logic        dbus_ack_i = 1'b0;
  logic [31:0] dbus_rdata_i = '0;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_sel_o;
  logic        stallreq_o, adel_o, ades_o;

  int n_checks = 0;
  int n_errors = 0;
  bit ll_ref = 1'b0;

  logic [7:0] op_list [0:10] = '{EXE_ADDU_OP, EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                                 EXE_LW_OP, EXE_LL_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP,
                                 EXE_SC_OP};

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst          (rst_n),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .hi_i         (hi_i),
    .lo_i         (lo_i),
    .whilo_i      (whilo_i),
    .aluop_i      (aluop_i),
    .mem_addr_i   (mem_addr_i),
    .reg2_i       (reg2_i),
    .flush_i      (flush_i),
    .dbus_ack_i   (dbus_ack_i),
    .dbus_rdata_i (dbus_rdata_i),
    .dbus_req_o   (dbus_req_o),
    .dbus_we_o    (dbus_we_o),
    .dbus_addr_o  (dbus_addr_o),
    .dbus_sel_o   (dbus_sel_o),
    .dbus_wdata_o (dbus_wdata_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .whilo_o      (whilo_o),
    .stallreq_o   (stallreq_o),
    .adel_o       (adel_o),
    .ades_o       (ades_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP:            return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:            return 2;
      EXE_LW_OP, EXE_LL_OP, EXE_SW_OP, EXE_SC_OP:  return 4;
      default:                                     return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LL_OP};
  endfunction

  function automatic bit op_signed(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LH_OP};
  endfunction

  // Big-endian: byte offset o of an s-byte access covers lanes (3-o) down to (4-s-o).
  function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] addr);
    int s, o, m;
    s = op_size(op);
    o = int'(addr % 4);
    m = (1 << s) - 1;
    return 4'(m << (4 - s - o));
  endfunction

  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int s, o;
    logic [31:0] m, v;
    s = op_size(op);
    o = int'(addr % 4);
    m = (s == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * s)) - 32'd1;
    v = (rdata >> (8 * (4 - s - o))) & m;
    if (op_signed(op) && v[8 * s - 1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [7:0] op, input logic [31:0] reg2);
    case (op_size(op))
      1:       return {24'b0, reg2[7:0]} * 32'h0101_0101;
      2:       return {16'b0, reg2[15:0]} * 32'h0001_0001;
      default: return reg2;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input logic [7:0] op, input logic [31:0] addr, reg2, alu);
    aluop_i      = op;
    mem_addr_i   = addr;
    reg2_i       = reg2;
    wdata_i      = alu;
    wd_i         = 5'($urandom);
    wreg_i       = 1'($urandom);
    hi_i         = $urandom;
    lo_i         = $urandom;
    whilo_i      = 1'b1;
    dbus_rdata_i = $urandom;
  endtask

  // Runs one instruction from IDLE; called and returns at posedge+1.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, reg2, alu,
                        input int dly, input logic [31:0] rdata, input string nm);
    int s;
    bit ld;
    logic [31:0] exp;
    s  = op_size(op);
    ld = op_load(op);
    drive(op, addr, reg2, alu);
    #4;
    if (s == 0) begin
      check({nm, " wdata"}, wdata_o, alu);
      check({nm, " wreg"}, wreg_o, wreg_i);
      check({nm, " wd"}, wd_o, wd_i);
      check({nm, " hi"}, hi_o, hi_i);
      check({nm, " whilo"}, whilo_o, 1);
      check({nm, " stall"}, stallreq_o, 0);
      check({nm, " req"}, dbus_req_o, 0);
      @(posedge clk); #1;
      return;
    end
    if (addr % s != 0) begin
      check({nm, " adel"}, adel_o, ld);
      check({nm, " ades"}, ades_o, !ld);
      check({nm, " wreg"}, wreg_o, 0);
      check({nm, " req"}, dbus_req_o, 0);
      check({nm, " stall"}, stallreq_o, 0);
      @(posedge clk); #1;
      return;
    end
    if (op == EXE_SC_OP && !ll_ref) begin
      check({nm, " sc-fail req"}, dbus_req_o, 0);
      check({nm, " sc-fail stall"}, stallreq_o, 0);
      check({nm, " sc-fail wreg"}, wreg_o, 1);
      check({nm, " sc-fail wdata"}, wdata_o, 0);
      @(posedge clk); #1;
      return;
    end
    check({nm, " req"}, dbus_req_o, 1);
    check({nm, " stall"}, stallreq_o, 1);
    check({nm, " we"}, dbus_we_o, !ld);
    check({nm, " addr"}, dbus_addr_o, {addr[31:2], 2'b00});
    check({nm, " sel"}, dbus_sel_o, ref_sel(op, addr));
    if (!ld) check({nm, " bus wdata"}, dbus_wdata_o, ref_store(op, reg2));
    check({nm, " whilo stalled"}, whilo_o, 0);
    check({nm, " wreg stalled"}, wreg_o, 0);
    for (int i = 0; i <= dly; i++) begin
      @(posedge clk); #1;
      dbus_ack_i   = (i == dly);
      dbus_rdata_i = (i == dly) ? rdata : $urandom;
      #4;
      check({nm, " busy req"}, dbus_req_o, 1);
      check({nm, " busy stall"}, stallreq_o, 1);
      check({nm, " busy wreg"}, wreg_o, 0);
      check({nm, " busy addr"}, dbus_addr_o, {addr[31:2], 2'b00});
      check({nm, " busy sel"}, dbus_sel_o, ref_sel(op, addr));
    end
    @(posedge clk); #1;
    dbus_ack_i   = 1'b0;
    dbus_rdata_i = $urandom;
    if (op == EXE_LL_OP) ll_ref = 1'b1;
    if (op == EXE_SC_OP) ll_ref = 1'b0;
    exp = ld ? ref_load(op, addr, rdata) : (op == EXE_SC_OP ? 32'd1 : alu);
    #4;
    check({nm, " done stall"}, stallreq_o, 0);
    check({nm, " done req"}, dbus_req_o, 0);
    check({nm, " done wreg"}, wreg_o, wreg_i);
    check({nm, " done wdata"}, wdata_o, exp);
    @(posedge clk); #1;
  endtask

  task automatic run_idle_flush(input logic [7:0] op, input logic [31:0] addr);
    drive(op, addr, $urandom, $urandom);
    flush_i = 1'b1;
    #4;
    check("idle flush req", dbus_req_o, 0);
    check("idle flush stall", stallreq_o, 0);
    check("idle flush wreg", wreg_o, 0);
    check("idle flush wdata", wdata_o, 0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    ll_ref  = 1'b0;
  endtask

  // Flush lands while a LW is outstanding; EX/MEM turns into a bubble meanwhile.
  task automatic run_flush_drain(input logic [31:0] addr);
    drive(EXE_LW_OP, addr, 32'h0, 32'h0);
    #4;
    check("drain launch req", dbus_req_o, 1);
    @(posedge clk); #1;
    flush_i = 1'b1;
    drive(EXE_NOP_OP, 32'h0, 32'h0, 32'h0);
    #4;
    check("drain flush req", dbus_req_o, 1);
    check("drain flush addr", dbus_addr_o, {addr[31:2], 2'b00});
    check("drain flush stall", stallreq_o, 1);
    check("drain flush wreg", wreg_o, 0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    ll_ref  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dbus_ack_i = (i == 2);
      #4;
      check("drain req", dbus_req_o, 1);
      check("drain addr", dbus_addr_o, {addr[31:2], 2'b00});
      check("drain sel", dbus_sel_o, 4'b1111);
      check("drain stall", stallreq_o, 1);
      check("drain wreg", wreg_o, 0);
      @(posedge clk); #1;
    end
    dbus_ack_i = 1'b0;
    #4;
    check("post-drain req", dbus_req_o, 0);
    check("post-drain stall", stallreq_o, 0);
    check("post-drain wreg", wreg_o, wreg_i);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, " req"}, dbus_req_o, 0);
    check({nm, " addr"}, dbus_addr_o, 0);
    check({nm, " sel"}, dbus_sel_o, 0);
    check({nm, " stall"}, stallreq_o, 0);
    check({nm, " wreg"}, wreg_o, 0);
    check({nm, " wdata"}, wdata_o, 0);
    check({nm, " wd"}, wd_o, 0);
    check({nm, " hi"}, hi_o, 0);
    check({nm, " lo"}, lo_o, 0);
    check({nm, " whilo"}, whilo_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0]  op;
    logic [31:0] addr;
    int          s;

    // Reset with live inputs: every output must still read 0.
    drive(EXE_LW_OP, 32'h0000_0100, 32'h1, 32'h2);
    #3;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(EXE_ADDU_OP, 32'h0, 32'h0, 32'h1234_5678, 0, 32'h0, "addu");
    run_op(EXE_LB_OP, 32'h0000_0101, 32'h0, 32'h0, 1, 32'h11F2_3344, "lb");
    run_op(EXE_SH_OP, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 0, 32'h0, "sh");
    run_op(EXE_LW_OP, 32'h0000_0103, 32'h0, 32'h0, 0, 32'h0, "lw misaligned");
    run_op(EXE_SW_OP, 32'h0000_0102, 32'h0, 32'h0, 0, 32'h0, "sw misaligned");
    run_op(EXE_LHU_OP, 32'h0000_0202, 32'h0, 32'h0, 2, 32'h1234_8765, "lhu");
    run_op(EXE_LL_OP, 32'h0000_0040, 32'h0, 32'h0, 0, 32'hCAFE_F00D, "ll");
    run_op(EXE_SC_OP, 32'h0000_0040, 32'h5555_0001, 32'h0, 0, 32'h0, "sc ok");
    run_op(EXE_SC_OP, 32'h0000_0040, 32'h5555_0002, 32'h0, 0, 32'h0, "sc again");

    run_op(EXE_LL_OP, 32'h0000_0080, 32'h0, 32'h0, 0, 32'h0000_0001, "ll2");
    run_flush_drain(32'h0000_0084);
    run_op(EXE_SC_OP, 32'h0000_0080, 32'h7, 32'h0, 0, 32'h0, "sc after flush");

    // Asynchronous reset in the middle of an access.
    drive(EXE_LW_OP, 32'h0000_0300, 32'h0, 32'h0);
    #4;
    check("rst-mid launch req", dbus_req_o, 1);
    @(posedge clk); #1;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst-mid");
    @(posedge clk); #1;
    rst_n  = 1'b1;
    ll_ref = 1'b0;
    run_op(EXE_ADDU_OP, 32'h0, 32'h0, 32'h0BAD_F00D, 0, 32'h0, "post-rst addu");
    run_op(EXE_LW_OP, 32'h0000_0300, 32'h0, 32'h0, 0, 32'hDEAD_BEEF, "post-rst lw");

    for (int n = 0; n < 80; n++) begin
      op   = op_list[$urandom_range(10, 0)];
      s    = op_size(op);
      addr = $urandom;
      if (s > 0 && $urandom_range(3, 0) != 0) addr = addr & ~32'(s - 1);
      if ($urandom_range(7, 0) == 0) begin
        run_idle_flush(op, addr);
      end else begin
        run_op(op, addr, $urandom, $urandom, int'($urandom_range(3, 0)), $urandom, "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
